// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD card SPI byte transfer controller.
//   state_e        : transfer controller FSM states
//   INIT_CLOCKS    : SCLK cycles in the card power-up preamble
//   BYTE_BITS      : bits per full-duplex transfer
//   *_TOGGLES      : SCLK edges (half-periods) per request type
//   DEF_*_DIV      : default half-period dividers for a 50 MHz clk
package sd_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned INIT_CLOCKS  = 80;
    localparam int unsigned BYTE_BITS    = 8;
    localparam int unsigned INIT_TOGGLES = 2 * INIT_CLOCKS;
    localparam int unsigned XFER_TOGGLES = 2 * BYTE_BITS;
    localparam int unsigned TOG_W        = 8;

    localparam int unsigned DEF_SLOW_DIV = 62;
    localparam int unsigned DEF_FAST_DIV = 2;
    localparam int unsigned DEF_DIV_W    = 8;

endpackage

// File: rtl/sd_sclk_gen.sv
// SPI clock generator: half-period counter with a divider latched on load.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   en_i        : run the counter; when low, count clears and SCLK idles low
//   load_i      : latch the divider selected by fast_i
//   fast_i      : 0 = SLOW_DIV, 1 = FAST_DIV
//   sclk_o      : registered SPI clock, mode 0 (idles low)
//   rise_c_o    : combinational strobe, high in the cycle whose closing edge raises SCLK
//   fall_c_o    : combinational strobe, high in the cycle whose closing edge lowers SCLK
module sd_sclk_gen #(
    parameter int unsigned SLOW_DIV = 62,
    parameter int unsigned FAST_DIV = 2,
    parameter int unsigned DIV_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic load_i,
    input  logic fast_i,
    output logic sclk_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             tc_c;

    // Terminal count of the current half-period.
    assign tc_c     = en_i && (cnt_q == (div_q - DIV_W'(1)));
    assign rise_c_o = tc_c && !sclk_q;
    assign fall_c_o = tc_c &&  sclk_q;
    assign sclk_o   = sclk_q;

    // Next-state for divider, counter and SCLK.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (load_i) begin
            div_d = fast_i ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
        end
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tc_c) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= DIV_W'(SLOW_DIV);
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/sd_spi_xfer_ctrl.sv
// Byte-level SPI transfer controller for the SD card interface.
// Sequences the 80-clock power-up preamble and 8-bit full-duplex transfers.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   fast_mode   : divider select, sampled when a request is accepted
//   init_req    : request the preamble (CS high, MOSI high); wins over start
//   start       : request one byte transfer
//   tx_byte     : byte to send MSB first, sampled on accept
//   cs_assert   : drive CS active outside the preamble
//   miso        : card data out
//   sclk, mosi, cs_n : card pins (mode 0)
//   busy        : preamble or transfer in progress
//   done        : one-cycle completion pulse
//   rx_byte     : last received byte, valid from done onward
module sd_spi_xfer_ctrl
    import sd_spi_pkg::*;
#(
    parameter int unsigned SLOW_DIV = DEF_SLOW_DIV,
    parameter int unsigned FAST_DIV = DEF_FAST_DIV,
    parameter int unsigned DIV_W    = DEF_DIV_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fast_mode,
    input  logic       init_req,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       cs_assert,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic [6:0]       tx_sh_q, tx_sh_d;   // bits still to send after the current one
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [TOG_W-1:0] tog_q, tog_d;

    logic             accept_c;
    logic             gen_en_c;
    logic             rise_c;
    logic             fall_c;
    logic             sclk_gen;

    assign gen_en_c = (state_q == ST_INIT) || (state_q == ST_XFER);

    sd_sclk_gen #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV),
        .DIV_W    (DIV_W)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .en_i     (gen_en_c),
        .load_i   (accept_c),
        .fast_i   (fast_mode),
        .sclk_o   (sclk_gen),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mosi_d    = mosi_q;
        rx_byte_d = rx_byte_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        tog_d     = tog_q;
        accept_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                mosi_d = 1'b1;
                tog_d  = '0;
                if (init_req || start) begin
                    accept_c = 1'b1;
                    busy_d   = 1'b1;
                    tx_sh_d  = tx_byte[6:0];
                    rx_sh_d  = '0;
                    if (init_req) begin
                        state_d = ST_INIT;
                    end else begin
                        state_d = ST_XFER;
                        mosi_d  = tx_byte[7];
                    end
                end
            end

            ST_INIT: begin
                mosi_d = 1'b1;
                // The last toggle is always a falling edge, so SCLK ends low.
                if (rise_c || fall_c) begin
                    if (tog_q == TOG_W'(INIT_TOGGLES - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tog_d   = '0;
                    end else begin
                        tog_d = tog_q + TOG_W'(1);
                    end
                end
            end

            ST_XFER: begin
                if (rise_c) begin
                    rx_sh_d = {rx_sh_q[6:0], miso};
                end
                if (rise_c || fall_c) begin
                    if (tog_q == TOG_W'(XFER_TOGGLES - 1)) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        mosi_d    = 1'b1;
                        tog_d     = '0;
                        rx_byte_d = rx_sh_q;
                    end else begin
                        tog_d = tog_q + TOG_W'(1);
                        if (fall_c) begin
                            mosi_d  = tx_sh_q[6];
                            tx_sh_d = {tx_sh_q[5:0], 1'b0};
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mosi_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mosi_d  = 1'b1;
            end
        endcase

        // Keyed on the next state so CS is already high in the first INIT cycle.
        cs_n_d = (state_d == ST_INIT) ? 1'b1 : ~cs_assert;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            rx_byte_q <= 8'h00;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            tog_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            rx_byte_q <= rx_byte_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            tog_q     <= tog_d;
        end
    end

    assign sclk    = sclk_gen;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_byte = rx_byte_q;

endmodule

// File: tb/tb_sd_spi_xfer_ctrl.sv
// Directed bench for sd_spi_xfer_ctrl with SLOW_DIV=4, FAST_DIV=2.
module tb_sd_spi_xfer_ctrl;

    logic       clk;
    logic       reset;
    logic       fast_mode;
    logic       init_req;
    logic       start;
    logic [7:0] tx_byte;
    logic       cs_assert;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;

    logic       loop_en;
    logic       miso_fix;

    int total;
    int bad;

    assign miso = loop_en ? mosi : miso_fix;

    sd_spi_xfer_ctrl #(
        .SLOW_DIV (4),
        .FAST_DIV (2),
        .DIV_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fast_mode (fast_mode),
        .init_req  (init_req),
        .start     (start),
        .tx_byte   (tx_byte),
        .cs_assert (cs_assert),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .busy      (busy),
        .done      (done),
        .rx_byte   (rx_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observes one request from its first busy cycle until a few cycles after done.
    // Request inputs are released after the first sampled cycle.
    task automatic measure(input bit poke,
                           output int busy_n, output int rises, output logic [7:0] bits,
                           output int dones, output int viol, output int csn_low,
                           output logic [7:0] rx_d, output logic sclk_d, output logic mosi_d);
        int   post;
        bit   seen;
        logic prev;
        busy_n = 0; rises = 0; bits = 8'h00; dones = 0; viol = 0; csn_low = 0;
        rx_d = 8'hxx; sclk_d = 1'bx; mosi_d = 1'bx;
        post = 0; seen = 0; prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (cs_n !== 1'b1 || mosi !== 1'b1) viol++;
                if (cs_n === 1'b0) csn_low++;
            end
            if (sclk === 1'b1 && prev === 1'b0) begin
                rises++;
                bits = {bits[6:0], mosi};
            end
            prev = sclk;
            if (done === 1'b1) begin
                dones++;
                rx_d   = rx_byte;
                sclk_d = sclk;
                mosi_d = mosi;
                seen   = 1'b1;
            end
            init_req = 1'b0;
            start    = 1'b0;
            if (poke && busy_n == 10) begin
                start     = 1'b1;
                fast_mode = ~fast_mode;
                tx_byte   = 8'h00;
            end
            if (seen) begin
                post++;
                if (post > 5) break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int         busy_n, rises, dones, viol, csn_low, rst_dones;
    logic [7:0] bits, rx_d;
    logic       sclk_d, mosi_d;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; fast_mode = 1'b0; init_req = 1'b0; start = 1'b0;
        tx_byte = 8'h00; cs_assert = 1'b1; loop_en = 1'b1; miso_fix = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd1);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx",   32'(rx_byte), 32'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_cs_n", 32'(cs_n), 32'd0);

        // Slow loopback A5
        fast_mode = 1'b0; tx_byte = 8'hA5; start = 1'b1;
        measure(1'b0, busy_n, rises, bits, dones, viol, csn_low, rx_d, sclk_d, mosi_d);
        chk("slow_busy",  32'(busy_n), 32'd64);
        chk("slow_rises", 32'(rises), 32'd8);
        chk("slow_bits",  32'(bits), 32'hA5);
        chk("slow_dones", 32'(dones), 32'd1);
        chk("slow_rx",    32'(rx_d), 32'hA5);
        chk("slow_dsclk", 32'(sclk_d), 32'd0);
        chk("slow_dmosi", 32'(mosi_d), 32'd1);
        chk("slow_csn",   32'(csn_low), 32'd64);

        // Fast 3C with miso=1; mid-transfer start, fast_mode flip and tx change ignored
        loop_en = 1'b0; miso_fix = 1'b1;
        @(negedge clk);
        fast_mode = 1'b1; tx_byte = 8'h3C; start = 1'b1;
        measure(1'b1, busy_n, rises, bits, dones, viol, csn_low, rx_d, sclk_d, mosi_d);
        chk("fast_busy",  32'(busy_n), 32'd32);
        chk("fast_rises", 32'(rises), 32'd8);
        chk("fast_bits",  32'(bits), 32'h3C);
        chk("fast_dones", 32'(dones), 32'd1);
        chk("fast_rx",    32'(rx_d), 32'hFF);

        // Init preamble, slow divider
        loop_en = 1'b1;
        @(negedge clk);
        fast_mode = 1'b0; init_req = 1'b1;
        measure(1'b0, busy_n, rises, bits, dones, viol, csn_low, rx_d, sclk_d, mosi_d);
        chk("init_busy",  32'(busy_n), 32'd640);
        chk("init_rises", 32'(rises), 32'd80);
        chk("init_viol",  32'(viol), 32'd0);
        chk("init_dones", 32'(dones), 32'd1);
        chk("init_rx",    32'(rx_d), 32'hFF);
        chk("init_dsclk", 32'(sclk_d), 32'd0);

        // init_req and start together: INIT wins, start dropped
        @(negedge clk);
        chk("prio_idle_csn", 32'(cs_n), 32'd0);
        init_req = 1'b1; start = 1'b1; tx_byte = 8'h12;
        measure(1'b0, busy_n, rises, bits, dones, viol, csn_low, rx_d, sclk_d, mosi_d);
        chk("prio_busy",  32'(busy_n), 32'd640);
        chk("prio_rises", 32'(rises), 32'd80);
        chk("prio_viol",  32'(viol), 32'd0);
        chk("prio_dones", 32'(dones), 32'd1);
        chk("prio_rx",    32'(rx_d), 32'hFF);

        // Reset during XFER at bit 3
        @(negedge clk);
        tx_byte = 8'h96; start = 1'b1;
        rises = 0; sclk_d = 1'b0;
        for (int c = 0; c < 500 && rises < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (sclk === 1'b1 && sclk_d === 1'b0) rises++;
            sclk_d = sclk;
        end
        chk("mid_rises", 32'(rises), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_sclk", 32'(sclk), 32'd0);
        chk("mid_cs_n", 32'(cs_n), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_mosi", 32'(mosi), 32'd1);
        chk("mid_rx",   32'(rx_byte), 32'h00);
        rst_dones = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) rst_dones++;
        end
        chk("mid_quiet", 32'(rst_dones), 32'd0);

        // New transfer after reset completes normally
        tx_byte = 8'hC3; start = 1'b1;
        measure(1'b0, busy_n, rises, bits, dones, viol, csn_low, rx_d, sclk_d, mosi_d);
        chk("post_busy",  32'(busy_n), 32'd64);
        chk("post_bits",  32'(bits), 32'hC3);
        chk("post_dones", 32'(dones), 32'd1);
        chk("post_rx",    32'(rx_d), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
